hard_sector_tracker: RTL and testbench
======================================

# hard_sector_tracker

Tracks the current hard sector on a hard-sectored disc by consuming the synchronised index-hole pulse train together with the track-mark detector's `detect` level. It sits directly downstream of the track-mark detector. On each track mark it resynchronises a sector counter and latches the measured sectors-per-revolution. On each ordinary sector hole it emits a sector-start strobe, the current sector number and a target-sector match pulse, which the acquisition start logic uses.

## Interface

Parameters:
- `SECTOR_BITS`, default 6: width of the sector number and the sector count (max 2^SECTOR_BITS−1 sectors).

Ports:
- `clock` input, 1: system clock, positive-edge-triggered.
- `reset` input, 1: reset, synchronous, active-high.
- `index` input, 1: index/sector-hole pulse, active high, already synchronised to `clock`.
- `track_mark` input, 1: track-mark `detect` level; it updates on the index rising edge.
- `target_sector` input, SECTOR_BITS: sector number to match.
- `sector` output, SECTOR_BITS: current sector number.
- `sector_valid` output, 1: high once a track mark has been seen since reset.
- `sector_strobe` output, 1: one-cycle pulse at the start of each sector.
- `match` output, 1: one-cycle pulse, coincident with `sector_strobe`, when the new `sector` equals `target_sector`.
- `sectors_per_rev` output, SECTOR_BITS: number of sectors counted between the last two track marks.
- `rev_valid` output, 1: high once `sectors_per_rev` holds a full-revolution count.
- `overflow` output, 1: sticky error, sector counter saturated.

## Operation

- Edge detection: register `index` into `idx_d`. An edge occurs in cycle T when `index`=1 and `idx_d`=0.
  - `idx_d` resets to 1, so an `index` already high at reset release is not an edge.
  - Only rising edges count; pulse width is irrelevant.
- Two-state classification pipeline: edge in cycle T sets `pending`. In cycle T+1, `track_mark` is sampled and `pending` is cleared.
  - The one-cycle delay lets the detector's output settle after the same index edge.
- Classification at T+1, track mark (`track_mark`=1):
  - If `sector_valid`=1: `sectors_per_rev` ← `strobe_count`, and `rev_valid` ← 1.
  - `strobe_count` ← 0; `armed` ← 1; `sector_valid` ← 1.
  - No `sector_strobe`; `sector` is unchanged.
- Classification at T+1, sector hole (`track_mark`=0):
  - If `sector_valid`=0, ignore it; no outputs change.
  - If `armed`=1: `sector` ← 0, `armed` ← 0, `strobe_count` ← 1, `sector_strobe` ← 1.
  - Otherwise, `sector` ← `sector`+1 and `strobe_count` ← `strobe_count`+1, saturating. Pulse `sector_strobe`.
  - `match` ← (new `sector` == `target_sector`), pulsed with the strobe.
- Saturation: if `sector` is already 2^SECTOR_BITS−1 when an increment is due:
  - `sector` holds and `overflow` ← 1.
  - The strobe is still issued; `match` is evaluated against the held value.
  - `strobe_count` saturates identically.
  - `overflow` clears only on `reset`.
- `target_sector` is sampled in the classification cycle only.

## Timing

- Reset values: `sector`=0, `sector_valid`=0, `sector_strobe`=0, `match`=0, `sectors_per_rev`=0, `rev_valid`=0, `overflow`=0. Internal state: `idx_d`=1, `pending`=0, `armed`=0, `strobe_count`=0.
- Latency: an index edge seen in cycle T gives classification in T+1. Registered outputs (`sector`, `sector_strobe`, `match`, `sectors_per_rev`, `sector_valid`) are visible in T+2.
- `sector_strobe` and `match` are high for exactly one cycle.
- Minimum edge spacing is 2 cycles (high, low, high), so `pending` never collides with a new edge. No queueing is required.
- `reset` asserted mid-pipeline, including while `pending`=1, discards the pending classification. All outputs take their reset values on the next edge.
- `sector` holds its value between strobes. It is meaningful only while `sector_valid`=1.

## Test plan

- Reset release with `index` held high, then `index` low: no edge, no strobe, `sector_valid`=0.
- Sector pulses before any track mark: `sector_strobe` stays 0. Then one track mark: `sector_valid`=1 at T+2, `sector` stays 0, no strobe.
- Track mark, then 4 sector holes, with `target_sector`=2: strobes show `sector`=0,1,2,3. `match` is high only with the strobe for sector 2, at T+2 of the third hole. `rev_valid`=0.
- Full revolution of 10 holes plus a track mark, repeated twice: after the second mark, `sectors_per_rev`=10 and `rev_valid`=1. `sector` restarts at 0 on the next hole.
- SECTOR_BITS=3 with 9 holes after a mark: strobes show 0..7, then 7 again. `overflow`=1 from the ninth strobe and stays set across the next track mark until `reset`.
- `reset` asserted in cycle T+1 of a sector-hole edge: no strobe in T+2. All outputs are at reset values and `sector_valid`=0.

Source files
------------

// File: rtl/hard_sector_tracker.sv
// Purpose : tracks the current hard sector from the index-hole pulse train and the track-mark level.
// Latency : an index edge in cycle T is classified in T+1; registered outputs are visible in T+2.
// Backpressure: none; edges are spaced at least two cycles apart, so nothing is queued.
//
// Ports:
//   clock, reset        - system clock; synchronous active-high reset
//   index               - synchronised index/sector-hole pulse (rising edge counts)
//   track_mark          - track-mark detector level, settles one cycle after the index edge
//   target_sector       - sector number to match; sampled only in the classification cycle
//   sector              - current sector number (meaningful while sector_valid)
//   sector_valid        - a track mark has been seen since reset
//   sector_strobe       - one-cycle pulse at the start of each sector
//   match               - one-cycle pulse with sector_strobe when the new sector == target_sector
//   sectors_per_rev     - sector holes counted between the last two track marks
//   rev_valid           - sectors_per_rev holds a full-revolution count
//   overflow            - sticky: sector counter saturated; cleared only by reset

module hard_sector_tracker #(
    parameter int SECTOR_BITS = 6
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   index,
    input  logic                   track_mark,
    input  logic [SECTOR_BITS-1:0] target_sector,
    output logic [SECTOR_BITS-1:0] sector,
    output logic                   sector_valid,
    output logic                   sector_strobe,
    output logic                   match,
    output logic [SECTOR_BITS-1:0] sectors_per_rev,
    output logic                   rev_valid,
    output logic                   overflow
);

    localparam logic [SECTOR_BITS-1:0] SECTOR_MAX = '1;
    localparam logic [SECTOR_BITS-1:0] SECTOR_ONE = SECTOR_BITS'(1);

    // ST_CLASSIFY is the single cycle after an index edge in which the
    // track-mark level is sampled to decide between a mark and a sector hole.
    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_CLASSIFY = 1'b1
    } state_t;

    state_t state;
    state_t state_nxt;

    logic                   idx_d;
    logic                   index_edge;
    logic                   armed;
    logic [SECTOR_BITS-1:0] strobe_count;

    logic [SECTOR_BITS-1:0] sector_nxt;
    logic                   sector_valid_nxt;
    logic                   sector_strobe_nxt;
    logic                   match_nxt;
    logic [SECTOR_BITS-1:0] sectors_per_rev_nxt;
    logic                   rev_valid_nxt;
    logic                   overflow_nxt;
    logic                   armed_nxt;
    logic [SECTOR_BITS-1:0] strobe_count_nxt;

    // idx_d resets high so an index already asserted at reset release is
    // not mistaken for a fresh edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            idx_d <= 1'b1;
        end else begin
            idx_d <= index;
        end
    end

    assign index_edge = index & ~idx_d;

    // Classification state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and next-output logic. Strobe and match default low so
    // they can only ever be one cycle wide.
    always_comb begin
        state_nxt           = index_edge ? ST_CLASSIFY : ST_IDLE;
        sector_nxt          = sector;
        sector_valid_nxt    = sector_valid;
        sector_strobe_nxt   = 1'b0;
        match_nxt           = 1'b0;
        sectors_per_rev_nxt = sectors_per_rev;
        rev_valid_nxt       = rev_valid;
        overflow_nxt        = overflow;
        armed_nxt           = armed;
        strobe_count_nxt    = strobe_count;

        if (state == ST_CLASSIFY) begin
            if (track_mark) begin
                // The first mark after reset only establishes the origin;
                // a full-revolution count exists from the second mark on.
                if (sector_valid) begin
                    sectors_per_rev_nxt = strobe_count;
                    rev_valid_nxt       = 1'b1;
                end
                strobe_count_nxt = '0;
                armed_nxt        = 1'b1;
                sector_valid_nxt = 1'b1;
            end else if (sector_valid) begin
                sector_strobe_nxt = 1'b1;
                if (armed) begin
                    // First hole after a mark is sector 0 regardless of
                    // where the counter was left.
                    sector_nxt       = '0;
                    armed_nxt        = 1'b0;
                    strobe_count_nxt = SECTOR_ONE;
                end else begin
                    if (sector == SECTOR_MAX) begin
                        overflow_nxt = 1'b1;
                    end else begin
                        sector_nxt = sector + SECTOR_ONE;
                    end
                    if (strobe_count != SECTOR_MAX) begin
                        strobe_count_nxt = strobe_count + SECTOR_ONE;
                    end
                end
                match_nxt = (sector_nxt == target_sector);
            end
        end
    end

    // Output and bookkeeping registers. A reset during ST_CLASSIFY simply
    // drops the pending classification.
    always_ff @(posedge clock) begin
        if (reset) begin
            sector          <= '0;
            sector_valid    <= 1'b0;
            sector_strobe   <= 1'b0;
            match           <= 1'b0;
            sectors_per_rev <= '0;
            rev_valid       <= 1'b0;
            overflow        <= 1'b0;
            armed           <= 1'b0;
            strobe_count    <= '0;
        end else begin
            sector          <= sector_nxt;
            sector_valid    <= sector_valid_nxt;
            sector_strobe   <= sector_strobe_nxt;
            match           <= match_nxt;
            sectors_per_rev <= sectors_per_rev_nxt;
            rev_valid       <= rev_valid_nxt;
            overflow        <= overflow_nxt;
            armed           <= armed_nxt;
            strobe_count    <= strobe_count_nxt;
        end
    end

endmodule

// File: tb/tb_hard_sector_tracker.sv
module tb_hard_sector_tracker;

    logic       clock = 1'b0;
    logic       reset;
    logic       index;
    logic       track_mark;
    logic [5:0] tgt6;
    logic [2:0] tgt3;

    logic [5:0] sec6, spr6;
    logic       val6, stb6, mat6, rv6, ov6;
    logic [2:0] sec3, spr3;
    logic       val3, stb3, mat3, rv3, ov3;

    always #5 clock = ~clock;

    hard_sector_tracker u6 (
        .clock(clock), .reset(reset), .index(index), .track_mark(track_mark),
        .target_sector(tgt6), .sector(sec6), .sector_valid(val6),
        .sector_strobe(stb6), .match(mat6), .sectors_per_rev(spr6),
        .rev_valid(rv6), .overflow(ov6)
    );

    hard_sector_tracker #(.SECTOR_BITS(3)) u3 (
        .clock(clock), .reset(reset), .index(index), .track_mark(track_mark),
        .target_sector(tgt3), .sector(sec3), .sector_valid(val3),
        .sector_strobe(stb3), .match(mat3), .sectors_per_rev(spr3),
        .rev_valid(rv3), .overflow(ov3)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: sector position derived from the number of holes
    // seen since the last track mark, clamped at each instance's maximum.
    int    m_max[2] = '{63, 7};
    int    m_h;
    bit    m_valid;
    int    m_sec[2];
    int    m_spr[2];
    int    m_tgt[2];
    bit    m_rv[2];
    bit    m_ovf[2];
    bit    e_stb[2];
    bit    e_mat[2];
    string names[7] = '{"sector", "sector_valid", "sector_strobe", "match",
                        "sectors_per_rev", "rev_valid", "overflow"};

    function automatic void model_reset();
        m_h     = 0;
        m_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            m_sec[i] = 0; m_spr[i] = 0; m_rv[i] = 1'b0; m_ovf[i] = 1'b0;
            e_stb[i] = 1'b0; e_mat[i] = 1'b0;
        end
    endfunction

    function automatic void model_event(input bit mark);
        for (int i = 0; i < 2; i++) begin
            e_stb[i] = 1'b0;
            e_mat[i] = 1'b0;
        end
        if (mark) begin
            if (m_valid) begin
                for (int i = 0; i < 2; i++) begin
                    m_spr[i] = (m_h < m_max[i]) ? m_h : m_max[i];
                    m_rv[i]  = 1'b1;
                end
            end
            m_h     = 0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            m_h = m_h + 1;
            for (int i = 0; i < 2; i++) begin
                if (m_h - 1 > m_max[i]) m_ovf[i] = 1'b1;
                m_sec[i] = (m_h - 1 < m_max[i]) ? m_h - 1 : m_max[i];
                e_stb[i] = 1'b1;
                e_mat[i] = (m_sec[i] == m_tgt[i]);
            end
        end
    endfunction

    function automatic int obs(input int i, input int k);
        case (k)
            0: return (i == 0) ? int'(sec6) : int'(sec3);
            1: return (i == 0) ? int'(val6) : int'(val3);
            2: return (i == 0) ? int'(stb6) : int'(stb3);
            3: return (i == 0) ? int'(mat6) : int'(mat3);
            4: return (i == 0) ? int'(spr6) : int'(spr3);
            5: return (i == 0) ? int'(rv6)  : int'(rv3);
            default: return (i == 0) ? int'(ov6) : int'(ov3);
        endcase
    endfunction

    function automatic int expv(input int i, input int k);
        case (k)
            0: return m_sec[i];
            1: return int'(m_valid);
            2: return int'(e_stb[i]);
            3: return int'(e_mat[i]);
            4: return m_spr[i];
            5: return int'(m_rv[i]);
            default: return int'(m_ovf[i]);
        endcase
    endfunction

    function automatic void set_targets(input int force_tgt);
        for (int i = 0; i < 2; i++)
            m_tgt[i] = (force_tgt >= 0) ? force_tgt : int'($urandom_range(0, m_max[i]));
        tgt6 = 6'(m_tgt[0]);
        tgt3 = 3'(m_tgt[1]);
    endfunction

    // One index pulse (mark or hole) with checks before, at and after T+2.
    task automatic run_event(input bit mark, input int force_tgt);
        int w;
        w = int'($urandom_range(1, 2));
        @(negedge clock);
        index = 1'b1;
        track_mark = mark;
        @(posedge clock);
        @(negedge clock);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (obs(i, 2) !== 0) begin
                errors++;
                $display("FAIL early_strobe inst%0d got %0d want 0", i, obs(i, 2));
            end
        end
        if (w == 1) index = 1'b0;
        track_mark = mark;
        set_targets(force_tgt);
        model_event(mark);
        @(posedge clock);
        @(negedge clock);
        index = 1'b0;
        track_mark = 1'($urandom_range(0, 1));
        tgt6 = 6'($urandom);
        tgt3 = 3'($urandom);
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < 7; k++) begin
                checks++;
                if (obs(i, k) !== expv(i, k)) begin
                    errors++;
                    $display("FAIL event_%s inst%0d mark=%0d got %0d want %0d",
                             names[k], i, mark, obs(i, k), expv(i, k));
                end
            end
        end
        @(posedge clock);
        @(negedge clock);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (obs(i, 2) !== 0 || obs(i, 3) !== 0) begin
                errors++;
                $display("FAIL pulse_width inst%0d strobe %0d match %0d want 0 0",
                         i, obs(i, 2), obs(i, 3));
            end
        end
        repeat ($urandom_range(0, 2)) @(negedge clock);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        index = 1'b0;
        track_mark = 1'b0;
        tgt6 = '0;
        tgt3 = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        index = 1'b1;
        model_reset();
        for (int c = 0; c < 6; c++) begin
            if (c == 4) index = 1'b0;
            @(posedge clock);
            @(negedge clock);
            for (int i = 0; i < 2; i++) begin
                for (int k = 0; k < 7; k++) begin
                    checks++;
                    if (obs(i, k) !== expv(i, k)) begin
                        errors++;
                        $display("FAIL reset_%s inst%0d cyc%0d got %0d want %0d",
                                 names[k], i, c, obs(i, k), expv(i, k));
                    end
                end
            end
        end
    endtask

    task automatic test_no_mark();
        repeat (3) run_event(1'b0, -1);
        run_event(1'b1, -1);
    endtask

    task automatic test_match();
        repeat (4) run_event(1'b0, 2);
    endtask

    task automatic test_overflow();
        run_event(1'b1, -1);
        repeat (9) run_event(1'b0, -1);
        run_event(1'b1, -1);
        run_event(1'b0, -1);
    endtask

    task automatic test_reset_mid();
        @(negedge clock);
        index = 1'b1;
        track_mark = 1'b0;
        @(posedge clock);
        @(negedge clock);
        index = 1'b0;
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        model_reset();
        for (int c = 0; c < 2; c++) begin
            for (int i = 0; i < 2; i++) begin
                for (int k = 0; k < 7; k++) begin
                    checks++;
                    if (obs(i, k) !== expv(i, k)) begin
                        errors++;
                        $display("FAIL midreset_%s inst%0d cyc%0d got %0d want %0d",
                                 names[k], i, c, obs(i, k), expv(i, k));
                    end
                end
            end
            @(posedge clock);
            @(negedge clock);
        end
    endtask

    task automatic test_revolution();
        repeat (2) begin
            run_event(1'b1, -1);
            repeat (10) run_event(1'b0, -1);
        end
        run_event(1'b1, -1);
        run_event(1'b0, -1);
    endtask

    // Edges exactly two cycles apart: high, low, high.
    task automatic test_back_to_back();
        @(negedge clock);
        index = 1'b1;
        track_mark = 1'b0;
        @(posedge clock);
        @(negedge clock);
        index = 1'b0;
        set_targets(-1);
        model_event(1'b0);
        @(posedge clock);
        @(negedge clock);
        index = 1'b1;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (obs(i, 2) !== expv(i, 2) || obs(i, 0) !== expv(i, 0) || obs(i, 3) !== expv(i, 3)) begin
                errors++;
                $display("FAIL b2b_first inst%0d got stb %0d sec %0d mat %0d want %0d %0d %0d",
                         i, obs(i, 2), obs(i, 0), obs(i, 3), expv(i, 2), expv(i, 0), expv(i, 3));
            end
        end
        @(posedge clock);
        @(negedge clock);
        index = 1'b0;
        set_targets(-1);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (obs(i, 2) !== 0) begin
                errors++;
                $display("FAIL b2b_gap inst%0d strobe got %0d want 0", i, obs(i, 2));
            end
        end
        model_event(1'b0);
        @(posedge clock);
        @(negedge clock);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (obs(i, 2) !== expv(i, 2) || obs(i, 0) !== expv(i, 0) || obs(i, 3) !== expv(i, 3)) begin
                errors++;
                $display("FAIL b2b_second inst%0d got stb %0d sec %0d mat %0d want %0d %0d %0d",
                         i, obs(i, 2), obs(i, 0), obs(i, 3), expv(i, 2), expv(i, 0), expv(i, 3));
            end
        end
        repeat (2) @(negedge clock);
    endtask

    task automatic test_random();
        for (int n = 0; n < 60; n++)
            run_event($urandom_range(0, 5) == 0, -1);
    endtask

    initial begin
        test_reset();
        test_no_mark();
        test_match();
        test_overflow();
        test_reset_mid();
        test_revolution();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
